// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the banked RAM (ram_banked / ram_bank).
//   state_t  : controller states CLEAR (initialisation sweep) and READY.
//   ram_log2 : ceiling log2, used to size the bank-select field.
// No ports; imported by ram_banked.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Ceiling log2 of n (returns 0 for n <= 1).
  function automatic int ram_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// ram_bank -- one storage bank: synchronous write, registered read.
// Ports:
//   clk     : clock
//   i_we    : write strobe, writes i_wdata to i_addr at the edge
//   i_re    : read strobe, captures the word at i_addr into o_rdata
//   i_addr  : word index inside the bank (shared by read and write)
//   i_wdata : write data
//   o_rdata : registered read data; returns i_wdata when writing the
//             same word in the same cycle (write-first)
// The array carries no reset; the top gates the output until the
// initialisation sweep has cleared every word.
module ram_bank #(
  parameter int DW    = 64,
  parameter int AW    = 3,
  parameter int WORDS = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_rdata;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read port; a concurrent write to the same word wins.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= i_we ? i_wdata : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_banked.sv
// ram_banked -- banked single-port RAM with a zeroing sweep after reset.
// After rst the controller writes zero to every word (one per cycle,
// ascending) with busy=1, then serves reads every cycle and writes on load.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, restarts the sweep
//   in         : write data (WIDTH bits)
//   addr       : word address for both read and write (ADDR_W bits)
//   load       : write strobe
//   out        : read data, one cycle after addr is sampled; 0 while busy
//   busy       : initialisation sweep in progress, requests ignored
//   parity_err : (only with RAM_BANKED_PARITY_EN) stored even parity check
//                failed on the word presented on out
// Optional feature: define RAM_BANKED_PARITY_EN to store one parity bit per
// word and add the parity_err output.
module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6,
  parameter int BANKS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  output logic [WIDTH-1:0]  out,
  output logic              busy
`ifdef RAM_BANKED_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int LB         = ram_log2(BANKS);
  localparam int SEL_W      = (LB == 0) ? 1 : LB;
  localparam int IDX_W      = ADDR_W - LB;
  localparam int IDX_WP     = (IDX_W == 0) ? 1 : IDX_W;
  localparam int BANK_WORDS = DEPTH / BANKS;
`ifdef RAM_BANKED_PARITY_EN
  localparam int MEM_W      = WIDTH + 1;
`else
  localparam int MEM_W      = WIDTH;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_sweep_addr;
  logic                w_sweep_last;
  logic                w_busy;

  logic [ADDR_W-1:0]   w_addr_eff;
  logic [MEM_W-1:0]    w_wdata;
  logic                w_we_any;
  logic                w_re;
  logic [SEL_W-1:0]    w_sel;
  logic [IDX_WP-1:0]   w_idx;

  logic [SEL_W-1:0]    r_sel_q;
  logic                r_out_en;
  logic [MEM_W-1:0]    w_rdata [BANKS];
  logic [MEM_W-1:0]    w_rdata_sel;

  assign w_sweep_last = (r_sweep_addr == ADDR_W'(DEPTH - 1));

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: leave CLEAR after the last word is zeroed; READY is terminal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR: begin
        if (w_sweep_last) begin
          w_next_state = READY;
        end else begin
          w_next_state = CLEAR;
        end
      end
      READY:   w_next_state = READY;
      default: w_next_state = CLEAR;
    endcase
  end

  // Output decode: busy is high for the whole of CLEAR.
  always_comb begin
    w_busy = 1'b1;
    case (r_state)
      CLEAR:   w_busy = 1'b1;
      READY:   w_busy = 1'b0;
      default: w_busy = 1'b1;
    endcase
  end

  assign busy = w_busy;

  // Sweep address counter; holds at the last word so it never re-enters CLEAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweep_addr <= '0;
    end else if ((r_state == CLEAR) && !w_sweep_last) begin
      r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
    end
  end

  // Access path: the sweep owns the array in CLEAR, the host in READY.
  // rst suppresses any write at the same edge.
  always_comb begin
    w_addr_eff = r_sweep_addr;
    w_wdata    = '0;
    w_we_any   = 1'b0;
    w_re       = 1'b0;
    case (r_state)
      CLEAR: begin
        w_addr_eff = r_sweep_addr;
        w_wdata    = '0;
        w_we_any   = !rst;
        w_re       = 1'b0;
      end
      READY: begin
        w_addr_eff = addr;
`ifdef RAM_BANKED_PARITY_EN
        w_wdata    = {^in, in};
`else
        w_wdata    = in;
`endif
        w_we_any   = !rst && load;
        w_re       = !rst;
      end
      default: begin
        w_addr_eff = r_sweep_addr;
        w_wdata    = '0;
        w_we_any   = 1'b0;
        w_re       = 1'b0;
      end
    endcase
  end

  // Address split: top LB bits pick the bank, the rest index inside it.
  if (LB == 0) begin : g_split_one
    assign w_sel = '0;
    assign w_idx = w_addr_eff;
  end else if (LB == ADDR_W) begin : g_split_word
    assign w_sel = w_addr_eff;
    assign w_idx = '0;
  end else begin : g_split
    assign w_sel = w_addr_eff[ADDR_W-1 -: LB];
    assign w_idx = w_addr_eff[IDX_W-1:0];
  end

  // Bank index of the previous read, and output enable that keeps out at 0
  // until the first read issued in READY has returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_q  <= '0;
      r_out_en <= 1'b0;
    end else begin
      r_sel_q  <= w_sel;
      r_out_en <= (r_state == READY);
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic w_bank_we;
    assign w_bank_we = w_we_any && (w_sel == SEL_W'(b));

    ram_bank #(
      .DW    (MEM_W),
      .AW    (IDX_WP),
      .WORDS (BANK_WORDS)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_bank_we),
      .i_re    (w_re),
      .i_addr  (w_idx),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata[b])
    );
  end

  // Output mux on the registered bank index, forced to 0 when not enabled.
  always_comb begin
    if (r_out_en) begin
      w_rdata_sel = w_rdata[r_sel_q];
    end else begin
      w_rdata_sel = '0;
    end
  end

  assign out = w_rdata_sel[WIDTH-1:0];

`ifdef RAM_BANKED_PARITY_EN
  // Even parity over data plus stored bit; a zeroed (gated) word checks clean.
  assign parity_err = ^w_rdata_sel;
`endif

endmodule

// File: doc/ram_banked.md
RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter BANKS, default 8, meaning number of storage banks; power of two, 1 <= BANKS <= DEPTH.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-006 The block SHALL have port in, input, WIDTH, meaning write data.
REQ-007 The block SHALL have port addr, input, ADDR_W, meaning word address for both read and write.
REQ-008 The block SHALL have port load, input, 1, meaning write strobe: write in to addr at this edge.
REQ-009 The block SHALL have port out, output, WIDTH, meaning registered read data.
REQ-010 The block SHALL have port busy, output, 1, meaning the initialisation sweep is in progress and requests are ignored.

Function
REQ-011 Bank select SHALL be the top log2(BANKS) bits of addr; the remaining low bits index the word within the bank. With BANKS=1 all of addr is the word index.
REQ-012 The controller SHALL have two states: CLEAR and READY.
REQ-013 In CLEAR, the controller SHALL write zero to one word per cycle, in ascending order from address 0 to DEPTH-1, with busy=1.
REQ-014 After writing address DEPTH-1, the controller SHALL move to READY on the next edge; busy SHALL be 0 from that edge onward, so a sweep lasts exactly DEPTH cycles.
REQ-015 In CLEAR, load and addr SHALL be ignored and out SHALL be held at 0.
REQ-016 In READY, load=1 SHALL write in to mem[addr] at the edge.
REQ-017 In READY, out SHALL present mem[addr] one cycle after addr is sampled; the read latency is 1 and every cycle is a read.
REQ-018 On a read and write to the same address in the same cycle, out SHALL return the new in value (write-first).
REQ-019 Only the selected bank SHALL be written; all other banks SHALL retain their contents.
REQ-020 The sweep address counter SHALL be ADDR_W bits wide and SHALL NOT wrap back into CLEAR: READY is terminal until the next rst.

Reset
REQ-021 While rst=1 at an edge: state SHALL become CLEAR, the sweep counter 0, out 0 and busy 1.
REQ-022 rst asserted mid-sweep or in READY SHALL restart the sweep from address 0; partially cleared contents are irrelevant.
REQ-023 rst SHALL take priority over load at the same edge; the write is dropped.

Configuration
REQ-024 With macro RAM_BANKED_PARITY_EN defined, each word SHALL store one extra even-parity bit (^in) on write; the sweep writes parity 0.
REQ-025 With RAM_BANKED_PARITY_EN defined, an output parity_err (1 bit) SHALL assert, aligned with out, when the XOR of the read data and the stored parity is 1. parity_err SHALL reset to 0 and SHALL be 0 in CLEAR.
REQ-026 Without RAM_BANKED_PARITY_EN, the block SHALL have no parity storage and no parity_err port; all other behaviour is identical.

Structure
REQ-027 Shared package ram_pkg SHALL hold the state typedef (CLEAR and READY) and a function for log2 of the bank count.
REQ-028 The block SHALL use one sub-module, ram_bank: a single DEPTH/BANKS-word synchronous write, registered-read array, instantiated BANKS times via generate.
REQ-029 The output mux SHALL select on the registered bank index of the previous cycle.

Verification
REQ-030 Apply rst for 1 cycle, then release -> busy=1 for exactly 64 cycles, then 0; out=0 throughout.
REQ-031 In READY, write 0xDEAD_BEEF_0123_4567 to addr 9, then read addr 9 -> out matches one cycle after the read; addr 8 and addr 17 read 0.
REQ-032 Set load=1, addr=63, in=0xA5A5... -> out=0xA5A5... on the next cycle (write-first).
REQ-033 During CLEAR, drive load=1 at addr 5 with all-ones; after READY, read addr 5 -> 0.
REQ-034 After writes, assert rst at sweep cycle 30 -> busy stays 1 for 64 further cycles; every address then reads 0.
REQ-035 With RAM_BANKED_PARITY_EN defined, force-flip one stored data bit at addr 3, then read addr 3 -> parity_err=1 with out; reads of untouched addresses -> parity_err=0.
